// File: rtl/ingress_pkg.sv
// Shared types for the NMU ingress destination filter.
// State/drop-reason enums, tuser flag offsets, header depth helper.
package ingress_pkg;

  typedef enum logic [1:0] {
    HDR,
    FLUSH,
    PASS,
    DROP
  } state_e;

  typedef enum logic [1:0] {
    NONE,
    POISON,
    NOROUTE,
    TIMEOUT
  } drop_rsn_e;

  // route_mask starts at bit 0; flags sit above the mask
  localparam int TU_MASK_LSB = 0;
  localparam int TU_POISON   = 0;
  localparam int TU_DONE     = 1;
  localparam int TU_CONFIG   = 2;

  function automatic int hdr_depth(input int last_byte,
                                   input int bus_bytes);
    return last_byte / bus_bytes + 1;
  endfunction

endpackage

// File: rtl/ingress_hdr_fifo.sv
// Header beat buffer for the ingress destination filter.
// Synchronous FIFO with full/empty flags and a drop-time clear.
module ingress_hdr_fifo
  import ingress_pkg::*;
#(
  parameter int W     = 73,
  parameter int DEPTH = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wr_ok, rd_ok;

  assign full    = cnt_q == CW'(DEPTH);
  assign empty   = cnt_q == '0;
  assign wr_ok   = wr_en && !full;
  assign rd_ok   = rd_en && !empty;
  assign rd_data = mem_q[rptr_q];

  // pointer and occupancy update; clear discards everything
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (clr) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (wr_ok)
        wptr_d = (wptr_q == PW'(DEPTH - 1)) ? '0 : wptr_q + PW'(1);
      if (rd_ok)
        rptr_d = (rptr_q == PW'(DEPTH - 1)) ? '0 : rptr_q + PW'(1);
      cnt_d = cnt_q + CW'(wr_ok) - CW'(rd_ok);
    end
  end

  // pointer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // storage array
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_ok) begin
      mem_q[wptr_q] <= wr_data;
    end
  end

endmodule

// File: rtl/ingress_dest_filter.sv
// NMU ingress filter: buffers headers, resolves tdest or drops.
// Drop counters built only with INGRESS_DROP_CNT_EN defined.
module ingress_dest_filter
  import ingress_pkg::*;
#(
  parameter  int AXIS_BUS_WIDTH = 64,
  parameter  int AXIS_ID_WIDTH  = 4,
  parameter  int LAST_BYTE      = 41,
  parameter  int CNT_WIDTH      = 32,
  localparam int NUM_BUS_BYTES  = AXIS_BUS_WIDTH / 8,
  localparam int NUM_AXIS_ID    = 2 ** AXIS_ID_WIDTH
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic [AXIS_BUS_WIDTH-1:0]  axis_in_tdata,
  input  logic [NUM_BUS_BYTES-1:0]   axis_in_tkeep,
  input  logic                       axis_in_tlast,
  input  logic                       axis_in_tvalid,
  output logic                       axis_in_tready,
  input  logic [NUM_AXIS_ID+3:0]     axis_in_tuser,
  output logic [AXIS_BUS_WIDTH-1:0]  axis_out_tdata,
  output logic [NUM_BUS_BYTES-1:0]   axis_out_tkeep,
  output logic                       axis_out_tlast,
  output logic                       axis_out_tvalid,
  input  logic                       axis_out_tready,
  output logic [AXIS_ID_WIDTH:0]     axis_out_tdest,
  input  logic [AXIS_ID_WIDTH+1:0]   ingress_config_regs,
  input  logic                       cnt_clear,
  output logic [CNT_WIDTH-1:0]       drop_poison_cnt,
  output logic [CNT_WIDTH-1:0]       drop_noroute_cnt,
  output logic [CNT_WIDTH-1:0]       drop_timeout_cnt
);

  localparam int HDR_DEPTH = hdr_depth(LAST_BYTE, NUM_BUS_BYTES);
  localparam int FW        = AXIS_BUS_WIDTH + NUM_BUS_BYTES + 1;
  localparam int DW        = AXIS_ID_WIDTH + 1;

  state_e                    state_q, state_d;
  logic [DW-1:0]             dest_q, dest_d;
  logic [NUM_AXIS_ID-1:0]    mask;
  logic                      poison, done, is_cfg, onehot;
  logic                      rr_en, tu_unused, pass_thru;
  logic [DW-1:0]             rr_dest, dec_dest;
  logic [AXIS_ID_WIDTH-1:0]  uni_idx;
  drop_rsn_e                 rsn, drop_rsn;
  logic                      fifo_wr, fifo_rd, fifo_clr;
  logic                      fifo_full, fifo_empty;
  logic [FW-1:0]             fifo_rdata;
  logic [AXIS_BUS_WIDTH-1:0] f_data;
  logic [NUM_BUS_BYTES-1:0]  f_keep;
  logic                      f_last;

  assign mask      = axis_in_tuser[TU_MASK_LSB +: NUM_AXIS_ID];
  assign poison    = axis_in_tuser[NUM_AXIS_ID + TU_POISON];
  assign done      = axis_in_tuser[NUM_AXIS_ID + TU_DONE];
  assign is_cfg    = axis_in_tuser[NUM_AXIS_ID + TU_CONFIG];
  assign tu_unused = axis_in_tuser[NUM_AXIS_ID + 3];
  assign rr_en     = ingress_config_regs[0];
  assign rr_dest   = ingress_config_regs[AXIS_ID_WIDTH+1:1];
  assign onehot    = (mask & (mask - NUM_AXIS_ID'(1))) == '0;

  ingress_hdr_fifo #(
    .W     (FW),
    .DEPTH (HDR_DEPTH)
  ) u_fifo (
    .clk     (aclk),
    .rst_n   (aresetn),
    .clr     (fifo_clr),
    .wr_en   (fifo_wr),
    .wr_data ({axis_in_tlast, axis_in_tkeep, axis_in_tdata}),
    .rd_en   (fifo_rd),
    .rd_data (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign {f_last, f_keep, f_data} = fifo_rdata;

  // once the buffer has drained, FLUSH behaves as pass-through
  assign pass_thru = (state_q == PASS) ||
                     (state_q == FLUSH && fifo_empty);

  assign axis_out_tdata = pass_thru ? axis_in_tdata : f_data;
  assign axis_out_tkeep = pass_thru ? axis_in_tkeep : f_keep;
  assign axis_out_tlast = pass_thru ? axis_in_tlast : f_last;
  assign axis_out_tdest = dest_q;

  // index of the single set route bit
  always_comb begin
    uni_idx = '0;
    for (int i = 0; i < NUM_AXIS_ID; i++)
      if (mask[i]) uni_idx = AXIS_ID_WIDTH'(i);
  end

  // verdict of the current beat, first matching rule wins
  always_comb begin
    rsn      = NONE;
    dec_dest = '0;
    if (poison)
      rsn = POISON;
    else if (is_cfg && rr_en)
      dec_dest = rr_dest;
    else if (mask == '0)
      rsn = NOROUTE;
    else if (onehot)
      dec_dest = {1'b0, uni_idx};
    else
      dec_dest = {1'b1, {AXIS_ID_WIDTH{1'b0}}};
  end

  // packet FSM: header buffering, flush, pass-through, discard
  always_comb begin
    state_d         = state_q;
    dest_d          = dest_q;
    fifo_wr         = 1'b0;
    fifo_rd         = 1'b0;
    fifo_clr        = 1'b0;
    drop_rsn        = NONE;
    axis_in_tready  = 1'b0;
    axis_out_tvalid = 1'b0;
    unique case (state_q)
      HDR: begin
        axis_in_tready = !fifo_full;
        fifo_wr        = axis_in_tvalid;
        if (fifo_full) begin
          drop_rsn = TIMEOUT;
          fifo_clr = 1'b1;
          state_d  = DROP;
        end else if (axis_in_tvalid && (done || axis_in_tlast)) begin
          if (rsn != NONE) begin
            drop_rsn = rsn;
            fifo_clr = 1'b1;
            state_d  = axis_in_tlast ? HDR : DROP;
          end else begin
            dest_d  = dec_dest;
            state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        if (!fifo_empty) begin
          axis_out_tvalid = 1'b1;
          fifo_rd         = axis_out_tready;
          if (axis_out_tready && f_last) state_d = HDR;
        end else begin
          axis_out_tvalid = axis_in_tvalid;
          axis_in_tready  = axis_out_tready;
          state_d = (axis_in_tvalid && axis_out_tready &&
                     axis_in_tlast) ? HDR : PASS;
        end
      end
      PASS: begin
        axis_out_tvalid = axis_in_tvalid;
        axis_in_tready  = axis_out_tready;
        if (axis_in_tvalid && axis_out_tready && axis_in_tlast)
          state_d = HDR;
      end
      DROP: begin
        axis_in_tready = 1'b1;
        if (axis_in_tvalid && axis_in_tlast) state_d = HDR;
      end
    endcase
  end

  // state and resolved destination
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= HDR;
      dest_q  <= '0;
    end else begin
      state_q <= state_d;
      dest_q  <= dest_d;
    end
  end

`ifdef INGRESS_DROP_CNT_EN
  logic [CNT_WIDTH-1:0] pcnt_q, pcnt_d;
  logic [CNT_WIDTH-1:0] ncnt_q, ncnt_d;
  logic [CNT_WIDTH-1:0] tcnt_q, tcnt_d;
  logic                 cnt_unused;

  assign cnt_unused = tu_unused;

  function automatic logic [CNT_WIDTH-1:0] cnt_nxt(
    input logic [CNT_WIDTH-1:0] c,
    input logic                 inc,
    input logic                 clr
  );
    if (clr) return '0;
    if (inc && !(&c)) return c + CNT_WIDTH'(1);
    return c;
  endfunction

  // saturating drop counters, clear wins over increment
  always_comb begin
    pcnt_d = cnt_nxt(pcnt_q, drop_rsn == POISON, cnt_clear);
    ncnt_d = cnt_nxt(ncnt_q, drop_rsn == NOROUTE, cnt_clear);
    tcnt_d = cnt_nxt(tcnt_q, drop_rsn == TIMEOUT, cnt_clear);
  end

  // counter registers
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      pcnt_q <= '0;
      ncnt_q <= '0;
      tcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
      ncnt_q <= ncnt_d;
      tcnt_q <= tcnt_d;
    end
  end

  assign drop_poison_cnt  = pcnt_q;
  assign drop_noroute_cnt = ncnt_q;
  assign drop_timeout_cnt = tcnt_q;
`else
  logic cnt_unused;

  assign cnt_unused       = cnt_clear ^ (^drop_rsn) ^ tu_unused;
  assign drop_poison_cnt  = '0;
  assign drop_noroute_cnt = '0;
  assign drop_timeout_cnt = '0;
`endif

endmodule

// File: tb/tb_ingress_dest_filter.sv
// Scoreboard bench for ingress_dest_filter.
// Packet-level reference model; counters expected 0 unless INGRESS_DROP_CNT_EN.
`timescale 1ns/1ps
module tb_ingress_dest_filter;

  localparam int DEPTH = 41 / 8 + 1;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [63:0] in_tdata = '0;
  logic [7:0]  in_tkeep = '0;
  logic        in_tlast = 1'b0;
  logic        in_tvalid = 1'b0;
  logic        in_tready;
  logic [19:0] in_tuser = '0;
  logic [63:0] out_tdata;
  logic [7:0]  out_tkeep;
  logic        out_tlast;
  logic        out_tvalid;
  logic        out_tready = 1'b1;
  logic [4:0]  out_tdest;
  logic [5:0]  cfg_regs = '0;
  logic        cnt_clear = 1'b0;
  logic [31:0] pcnt, ncnt, tcnt;

  ingress_dest_filter dut (
    .aclk                (aclk),
    .aresetn             (aresetn),
    .axis_in_tdata       (in_tdata),
    .axis_in_tkeep       (in_tkeep),
    .axis_in_tlast       (in_tlast),
    .axis_in_tvalid      (in_tvalid),
    .axis_in_tready      (in_tready),
    .axis_in_tuser       (in_tuser),
    .axis_out_tdata      (out_tdata),
    .axis_out_tkeep      (out_tkeep),
    .axis_out_tlast      (out_tlast),
    .axis_out_tvalid     (out_tvalid),
    .axis_out_tready     (out_tready),
    .axis_out_tdest      (out_tdest),
    .ingress_config_regs (cfg_regs),
    .cnt_clear           (cnt_clear),
    .drop_poison_cnt     (pcnt),
    .drop_noroute_cnt    (ncnt),
    .drop_timeout_cnt    (tcnt)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic [19:0] tuser;
  } beat_t;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic [4:0]  dest;
  } exp_t;

  beat_t pkt[$];
  exp_t  sb[$];
  int    n_chk = 0;
  int    n_fail = 0;
  int    exp_cnt[3] = '{0, 0, 0};
  bit    bp_en = 0;
  bit    gap_en = 1;
  bit    abort = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_cnts(input string tag);
    logic [31:0] e[3];
    for (int k = 0; k < 3; k++) begin
`ifdef INGRESS_DROP_CNT_EN
      e[k] = exp_cnt[k];
`else
      e[k] = 0;
`endif
    end
    chk({tag, "_poison_cnt"}, pcnt, e[0]);
    chk({tag, "_noroute_cnt"}, ncnt, e[1]);
    chk({tag, "_timeout_cnt"}, tcnt, e[2]);
  endtask

  // build a packet; verdict fields placed on the intended decision beat
  task automatic make_pkt(input int len, input int done_at,
                          input bit poi, input bit cf,
                          input logic [15:0] mask);
    int dec;
    dec = (done_at >= 0 && done_at < len) ? done_at : len - 1;
    pkt.delete();
    for (int i = 0; i < len; i++) begin
      beat_t b;
      b.data = {$urandom, $urandom};
      b.keep = 8'($urandom);
      b.last = (i == len - 1);
      b.tuser = 20'($urandom);
      b.tuser[17] = (i == done_at);
      if (i == dec) begin
        b.tuser[16]   = poi;
        b.tuser[18]   = cf;
        b.tuser[15:0] = mask;
      end
      pkt.push_back(b);
    end
  endtask

  // packet-level reference: pick decision beat, apply rule list
  task automatic model(input logic [5:0] cfg);
    int d;
    logic [19:0] tu;
    logic [4:0] dest;
    d = -1;
    foreach (pkt[i])
      if (d < 0 && (pkt[i].tuser[17] || pkt[i].last)) d = i;
    if (d >= DEPTH) begin
      exp_cnt[2]++;
      return;
    end
    tu = pkt[d].tuser;
    if (tu[16]) begin
      exp_cnt[0]++;
      return;
    end
    if (tu[18] && cfg[0]) dest = cfg[5:1];
    else if (tu[15:0] == 16'h0) begin
      exp_cnt[1]++;
      return;
    end else if ($countones(tu[15:0]) == 1) begin
      dest = '0;
      for (int b = 0; b < 16; b++) if (tu[b]) dest = 5'(b);
    end else dest = 5'h10;
    foreach (pkt[i])
      sb.push_back('{pkt[i].data, pkt[i].keep, pkt[i].last, dest});
  endtask

  task automatic send_pkt(input logic [5:0] cfg);
    model(cfg);
    for (int i = 0; i < pkt.size(); i++) begin
      bit hs;
      int guard;
      hs = 0;
      guard = 0;
      if (gap_en && $urandom_range(0, 3) == 0) begin
        @(negedge aclk);
        cfg_regs = cfg;
        in_tvalid = 1'b0;
      end
      while (!hs) begin
        @(negedge aclk);
        if (abort) begin
          in_tvalid = 1'b0;
          return;
        end
        cfg_regs = cfg;
        in_tvalid = 1'b1;
        in_tdata = pkt[i].data;
        in_tkeep = pkt[i].keep;
        in_tlast = pkt[i].last;
        in_tuser = pkt[i].tuser;
        #1;
        hs = in_tready;
        guard++;
        if (!hs && guard > 2000) begin
          n_chk++;
          n_fail++;
          $display("FAIL in_accept: beat %0d not accepted, got tready=0 expected 1", i);
          in_tvalid = 1'b0;
          return;
        end
      end
    end
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    @(negedge aclk);
    in_tvalid = 1'b0;
    while (sb.size() != 0 && g < 3000) begin
      @(negedge aclk);
      g++;
    end
    chk("drain_pending_beats", sb.size(), 0);
    repeat (3) @(negedge aclk);
  endtask

  // output backpressure
  initial forever begin
    @(negedge aclk);
    out_tready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // monitor: pops expectations on each output handshake
  initial begin
    bit pv;
    logic [77:0] pval;
    exp_t e;
    pv = 0;
    pval = '0;
    forever begin
      @(negedge aclk);
      #2;
      if (!aresetn) begin
        pv = 0;
        continue;
      end
      if (pv) begin
        n_chk++;
        if (!out_tvalid ||
            {out_tdata, out_tkeep, out_tlast, out_tdest} !== pval) begin
          n_fail++;
          $display("FAIL stall_hold: got v=%0b %0h expected v=1 %0h",
                   out_tvalid, {out_tdata, out_tkeep, out_tlast, out_tdest}, pval);
        end
      end
      pv = out_tvalid && !out_tready;
      pval = {out_tdata, out_tkeep, out_tlast, out_tdest};
      if (out_tvalid && out_tready) begin
        n_chk++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL out_beat: got unexpected beat %0h expected none", out_tdata);
        end else begin
          e = sb.pop_front();
          if ({out_tdata, out_tkeep, out_tlast, out_tdest} !==
              {e.data, e.keep, e.last, e.dest}) begin
            n_fail++;
            $display("FAIL out_beat: got d=%0h k=%0h l=%0b dst=%0h expected d=%0h k=%0h l=%0b dst=%0h",
                     out_tdata, out_tkeep, out_tlast, out_tdest,
                     e.data, e.keep, e.last, e.dest);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge aclk);
    chk("rst_out_tvalid", 32'(out_tvalid), 0);
    chk("rst_out_tdest", 32'(out_tdest), 0);
    check_cnts("rst");
    aresetn = 1'b1;
    @(negedge aclk);
    #1;
    chk("rst_in_tready", 32'(in_tready), 1);

    // unicast, done on beat 2
    make_pkt(3, 1, 0, 0, 16'h0004);
    send_pkt(6'h00);
    wait_idle();

    // poison on first beat of 10, then a normal packet
    make_pkt(10, 0, 1, 0, 16'h0004);
    send_pkt(6'h00);
    make_pkt(4, 2, 0, 0, 16'h0100);
    send_pkt(6'h00);
    wait_idle();
    check_cnts("poison");

    // config reroute on and off
    make_pkt(3, 0, 0, 1, 16'h0001);
    send_pkt({5'h11, 1'b1});
    make_pkt(3, 0, 0, 1, 16'h0001);
    send_pkt({5'h11, 1'b0});
    wait_idle();

    // broadcast and noroute
    make_pkt(4, 1, 0, 0, 16'h8001);
    send_pkt(6'h00);
    make_pkt(4, 1, 0, 0, 16'h0000);
    send_pkt(6'h00);
    wait_idle();
    check_cnts("noroute");

    // timeout, then single-beat and drop-on-last cases
    make_pkt(8, -1, 0, 0, 16'h0002);
    send_pkt(6'h00);
    make_pkt(1, -1, 0, 0, 16'h0040);
    send_pkt(6'h00);
    make_pkt(2, 1, 1, 0, 16'h0040);
    send_pkt(6'h00);
    make_pkt(6, 5, 0, 0, 16'h0008);
    send_pkt(6'h00);
    wait_idle();
    check_cnts("timeout");

    // counter clear
    @(negedge aclk);
    cnt_clear = 1'b1;
    @(negedge aclk);
    cnt_clear = 1'b0;
    exp_cnt = '{0, 0, 0};
    #2;
    check_cnts("clear");

    // randomized traffic under backpressure
    bp_en = 1;
    for (int p = 0; p < 80; p++) begin
      int len, dn, sel;
      logic [15:0] m;
      len = $urandom_range(1, 10);
      dn = ($urandom_range(0, 4) == 0) ? -1 : $urandom_range(0, len + 1);
      sel = $urandom_range(0, 5);
      m = (sel == 0) ? 16'h0 :
          (sel < 4)  ? 16'h1 << $urandom_range(0, 15) : 16'($urandom);
      make_pkt(len, dn, $urandom_range(0, 6) == 0,
               $urandom_range(0, 2) == 0, m);
      send_pkt(6'($urandom));
    end
    wait_idle();
    check_cnts("random");

    // reset in the middle of a passing packet
    bp_en = 0;
    gap_en = 0;
    make_pkt(10, 0, 0, 0, 16'h0002);
    fork
      send_pkt(6'h00);
      begin
        repeat (5) @(posedge aclk);
        #2;
        aresetn = 1'b0;
        abort = 1;
      end
    join
    @(negedge aclk);
    #2;
    exp_cnt = '{0, 0, 0};
    chk("midrst_out_tvalid", 32'(out_tvalid), 0);
    chk("midrst_out_tdest", 32'(out_tdest), 0);
    check_cnts("midrst");
    sb.delete();
    @(negedge aclk);
    aresetn = 1'b1;
    abort = 0;
    gap_en = 1;
    #1;
    chk("midrst_in_tready", 32'(in_tready), 1);
    make_pkt(3, 2, 0, 0, 16'h0020);
    send_pkt(6'h00);
    make_pkt(3, 0, 1, 0, 16'h0020);
    send_pkt(6'h00);
    wait_idle();
    check_cnts("postrst");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
